gpio_bus_arbiter: RTL and testbench



---
 rtl/gpio_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_arbiter.sv
// Two-port round-robin arbiter in front of the GPIO core register port.
// One transaction at a time: IDLE (grant + capture) -> ACCESS (strobe) -> RESP (ack).
module gpio_bus_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          sysclk,
   input  logic          sysrst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          gpio_stb,
   output logic          gpio_we,
   output logic [AW-1:0] gpio_addr,
   output logic [DW-1:0] gpio_dat_i,
   input  logic [DW-1:0] gpio_dat_o,
   output logic          busy,
   output logic          gnt_id
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state, state_nx;
   logic   last_q, last_nx;
   logic   winner_c;
   logic   stb_nx, we_nx, ack0_nx, ack1_nx, busy_nx, gnt_nx;
   logic [AW-1:0] addr_nx;
   logic [DW-1:0] dat_nx, rdata0_nx, rdata1_nx, rd_c;

   // On a tie the port that did not win last time gets the bus
   assign winner_c = (req0 && req1) ? ~last_q : req1;
   assign rd_c     = gpio_we ? '0 : gpio_dat_o;

   // State register; output registers double as the captured request fields
   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         state      <= IDLE;
         last_q     <= 1'b1;
         gpio_stb   <= 1'b0;
         gpio_we    <= 1'b0;
         gpio_addr  <= '0;
         gpio_dat_i <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         busy       <= 1'b0;
         gnt_id     <= 1'b0;
      end else begin
         state      <= state_nx;
         last_q     <= last_nx;
         gpio_stb   <= stb_nx;
         gpio_we    <= we_nx;
         gpio_addr  <= addr_nx;
         gpio_dat_i <= dat_nx;
         ack0       <= ack0_nx;
         ack1       <= ack1_nx;
         rdata0     <= rdata0_nx;
         rdata1     <= rdata1_nx;
         busy       <= busy_nx;
         gnt_id     <= gnt_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req0 || req1) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      stb_nx    = 1'b0;
      we_nx     = 1'b0;
      addr_nx   = gpio_addr;
      dat_nx    = gpio_dat_i;
      ack0_nx   = 1'b0;
      ack1_nx   = 1'b0;
      rdata0_nx = '0;
      rdata1_nx = '0;
      busy_nx   = (state_nx != IDLE);
      gnt_nx    = gnt_id;
      last_nx   = last_q;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               gnt_nx  = winner_c;
               last_nx = winner_c;
               stb_nx  = 1'b1;
               we_nx   = winner_c ? we1 : we0;
               addr_nx = winner_c ? addr1 : addr0;
               if (winner_c) dat_nx = we1 ? wdata1 : '0;
               else          dat_nx = we0 ? wdata0 : '0;
            end
         end
         ACCESS: begin
            if (gnt_id) begin
               ack1_nx   = 1'b1;
               rdata1_nx = rd_c;
            end else begin
               ack0_nx   = 1'b1;
               rdata0_nx = rd_c;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench for gpio_bus_arbiter: vector table + scoreboard monitor,
// plus hand-written sequences for tie timing, field changes, back-to-back and reset.
module tb_gpio_bus_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          sysclk, sysrst;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, gpio_stb, gpio_we, busy, gnt_id;
   logic [DW-1:0] rdata0, rdata1, gpio_dat_i, gpio_dat_o;
   logic [AW-1:0] gpio_addr;

   gpio_bus_arbiter #(.AW(AW), .DW(DW)) dut (
      .sysclk(sysclk), .sysrst(sysrst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .gpio_stb(gpio_stb), .gpio_we(gpio_we), .gpio_addr(gpio_addr),
      .gpio_dat_i(gpio_dat_i), .gpio_dat_o(gpio_dat_o), .busy(busy), .gnt_id(gnt_id)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // GPIO core register model: combinational read data from address
   function automatic logic [DW-1:0] gpio_model(input logic [AW-1:0] a);
      if (a == 32'h8) return 32'h0000_00FF;
      return (a * 32'h0101_0101) ^ 32'hC3C3_0000;
   endfunction
   assign gpio_dat_o = gpio_model(gpio_addr);

   typedef struct {
      logic          port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] dat_i;
      logic [DW-1:0] rdata;
   } exp_t;

   typedef struct {
      logic          r0, w0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          r1, w1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      int            exp_busy;
   } vec_t;

   exp_t sb[$];
   logic last_exp;
   logic prev_stb;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.port  = p;
      e.we    = w;
      e.addr  = a;
      e.dat_i = w ? d : '0;
      e.rdata = w ? '0 : gpio_model(a);
      sb.push_back(e);
      last_exp = p;
   endtask

   // Scoreboard monitor and per-cycle protocol invariants
   initial prev_stb = 1'b0;
   always @(negedge sysclk) begin
      if (!sysrst) begin
         chk("we_without_stb", 32'(gpio_we & ~gpio_stb), 32'd0);
         chk("two_acks", 32'(ack0 & ack1), 32'd0);
         chk("stb_back_to_back", 32'(gpio_stb & prev_stb), 32'd0);
         if (!ack0) chk("rdata0_without_ack", rdata0, 32'd0);
         if (!ack1) chk("rdata1_without_ack", rdata1, 32'd0);
         if (gpio_stb) begin
            if (sb.size() == 0) chk("stb_unexpected", 32'd1, 32'd0);
            else begin
               chk("access_we", 32'(gpio_we), 32'(sb[0].we));
               chk("access_addr", gpio_addr, sb[0].addr);
               chk("access_dat_i", gpio_dat_i, sb[0].dat_i);
               chk("access_busy", 32'(busy), 32'd1);
            end
         end
         if (ack0 || ack1) begin
            if (sb.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("ack_port", 32'(ack1), 32'(e.port));
               chk("ack_rdata", ack1 ? rdata1 : rdata0, e.rdata);
               chk("ack_gnt_id", 32'(gnt_id), 32'(e.port));
               chk("ack_stb_low", 32'(gpio_stb), 32'd0);
            end
         end
      end
      prev_stb = sysrst ? 1'b0 : gpio_stb;
   end

   task automatic apply_reset();
      sysrst = 1'b1;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
      sb.delete();
      repeat (2) @(posedge sysclk);
      #1 sysrst = 1'b0;
      last_exp = 1'b1;
   endtask

   // Drive one vector, follow the requester protocol, and count busy cycles
   task automatic run_vec(input vec_t v, output int busy_cnt);
      logic a0, a1, first;
      bit   done0, done1, ok;
      busy_cnt = 0;
      @(posedge sysclk); #1;
      req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
      req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
      if (v.r0 && v.r1) begin
         first = ~last_exp;
         if (first) begin push(1, v.w1, v.a1, v.d1); push(0, v.w0, v.a0, v.d0); end
         else       begin push(0, v.w0, v.a0, v.d0); push(1, v.w1, v.a1, v.d1); end
      end else if (v.r0) push(0, v.w0, v.a0, v.d0);
      else if (v.r1)     push(1, v.w1, v.a1, v.d1);
      done0 = !v.r0;
      done1 = !v.r1;
      ok = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge sysclk);
         a0 = ack0; a1 = ack1;
         if (busy) busy_cnt++;
         @(posedge sysclk); #1;
         if (a0) begin req0 = 0; done0 = 1; end
         if (a1) begin req1 = 0; done1 = 1; end
         if (done0 && done1) begin ok = 1; break; end
      end
      if (!ok) begin
         chk("vec_timeout", 32'd1, 32'd0);
         req0 = 0; req1 = 0;
      end
   endtask

   function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0,
                               input logic r1, w1, input logic [31:0] a1, d1, input int b);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.exp_busy = b;
      return v;
   endfunction

   vec_t vecs[7];
   int   bcnt;
   logic log0[12];
   logic log1[12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(1, 1, 32'h04, 32'hA5A5_0001, 0, 0, 32'h0,  32'h0,         2);
      vecs[1] = mk(0, 0, 32'h0,  32'h0,         1, 0, 32'h08, 32'h0,         2);
      vecs[2] = mk(1, 0, 32'h0C, 32'h0,         1, 1, 32'h14, 32'h1234_5678, 4);
      vecs[3] = mk(1, 0, 32'h20, 32'hDEAD_BEEF, 0, 0, 32'h0,  32'h0,         2);
      vecs[4] = mk(1, 1, 32'h18, 32'h0BAD_F00D, 1, 0, 32'h1C, 32'h0,         4);
      vecs[5] = mk(0, 0, 32'h0,  32'h0,         1, 1, 32'h24, 32'hFFFF_FFFF, 2);
      vecs[6] = mk(1, 0, 32'h08, 32'h0,         1, 0, 32'h2C, 32'h0,         4);

      apply_reset();
      @(negedge sysclk);
      chk("rst_stb", 32'(gpio_stb), 32'd0);
      chk("rst_we", 32'(gpio_we), 32'd0);
      chk("rst_addr", gpio_addr, 32'd0);
      chk("rst_dat_i", gpio_dat_i, 32'd0);
      chk("rst_ack", 32'({ack1, ack0}), 32'd0);
      chk("rst_rdata", rdata0 | rdata1, 32'd0);
      chk("rst_busy_gnt", 32'({busy, gnt_id}), 32'd0);

      foreach (vecs[i]) begin
         run_vec(vecs[i], bcnt);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].exp_busy));
      end
      repeat (2) @(negedge sysclk);
      chk("vec_sb_drain", 32'(sb.size()), 32'd0);

      // Tie after reset with both held: grants 0,1,0,1
      apply_reset();
      @(posedge sysclk); #1;
      req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'h5555_AAAA;
      req1 = 1; we1 = 0; addr1 = 32'h08;
      push(0, 1, 32'h30, 32'h5555_AAAA); push(1, 0, 32'h08, '0);
      push(0, 1, 32'h30, 32'h5555_AAAA); push(1, 0, 32'h08, '0);
      for (int n = 0; n < 12; n++) begin
         @(negedge sysclk);
         log0[n] = ack0; log1[n] = ack1;
      end
      req0 = 0; req1 = 0;
      for (int n = 0; n < 12; n++) begin
         chk($sformatf("tie_ack0_c%0d", n), 32'(log0[n]), 32'((n == 2) || (n == 8)));
         chk($sformatf("tie_ack1_c%0d", n), 32'(log1[n]), 32'((n == 5) || (n == 11)));
      end
      repeat (3) @(negedge sysclk);
      chk("tie_sb_drain", 32'(sb.size()), 32'd0);

      // Fields changed after grant must not reach the GPIO port
      @(posedge sysclk); #1;
      req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'h1111_0000;
      push(0, 1, 32'h10, 32'h1111_0000);
      @(posedge sysclk); #1;
      addr0 = 32'h20; wdata0 = 32'h2222_0000;
      @(negedge sysclk);
      chk("chg_stb", 32'(gpio_stb), 32'd1);
      chk("chg_addr", gpio_addr, 32'h10);
      chk("chg_dat_i", gpio_dat_i, 32'h1111_0000);
      @(negedge sysclk);
      chk("chg_ack0", 32'(ack0), 32'd1);
      @(posedge sysclk); #1 req0 = 0;

      // Back-to-back single port: one ack every 3 cycles
      @(posedge sysclk); #1;
      req0 = 1; we0 = 0; addr0 = 32'h0C;
      repeat (3) push(0, 0, 32'h0C, '0);
      for (int n = 0; n < 9; n++) begin
         @(negedge sysclk);
         chk($sformatf("b2b_ack0_c%0d", n), 32'(ack0), 32'((n == 2) || (n == 5) || (n == 8)));
      end
      req0 = 0;
      repeat (3) @(negedge sysclk);
      chk("b2b_sb_drain", 32'(sb.size()), 32'd0);

      // Reset during ACCESS of a port-1 read: outputs clear immediately, no ack
      @(posedge sysclk); #1;
      req1 = 1; we1 = 0; addr1 = 32'h08;
      push(1, 0, 32'h08, '0);
      @(posedge sysclk); #2;
      chk("pre_rst_stb", 32'(gpio_stb), 32'd1);
      sysrst = 1'b1;
      sb.delete();
      #1;
      chk("mid_rst_stb", 32'(gpio_stb), 32'd0);
      chk("mid_rst_we", 32'(gpio_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ack1", 32'(ack1), 32'd0);
      req1 = 0;
      @(posedge sysclk); #1;
      chk("mid_rst_ack1_hold", 32'(ack1), 32'd0);
      sysrst = 1'b0;
      last_exp = 1'b1;
      repeat (2) @(negedge sysclk);
      chk("post_rst_no_ack", 32'({ack1, ack0}), 32'd0);
      run_vec(mk(1, 1, 32'h40, 32'hCAFE_0001, 1, 1, 32'h44, 32'hCAFE_0002, 4), bcnt);
      chk("post_rst_tie_busy", 32'(bcnt), 32'd4);
      repeat (2) @(negedge sysclk);
      chk("final_sb_drain", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
